// File: rtl/cpu_pkg.sv
// Shared decode-stage definitions: immediate extension modes and the
// occupancy states of the immediate skid buffer.
package cpu_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_SIGN      = 3'd0;
    localparam logic [MODE_W-1:0] MODE_ZERO      = 3'd1;
    localparam logic [MODE_W-1:0] MODE_UPPER     = 3'd2;
    localparam logic [MODE_W-1:0] MODE_SIGN_SHL2 = 3'd3;
    localparam logic [MODE_W-1:0] MODE_BYTE_SIGN = 3'd4;

    // Number of valid words held: none, main register only, main + skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extender: widens an IN_W-bit immediate to OUT_W
// bits according to the extension mode. Reserved modes yield zero with err.
module imm_extend_core
    import cpu_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]   data,
    input  logic [MODE_W-1:0] mode,
    output logic [OUT_W-1:0]  result,
    output logic              err
);

    logic signed [OUT_W-1:0] w_sext;
    logic signed [OUT_W-1:0] w_byte_sext;

    // Size casts of signed operands sign-extend, so no replication width
    // corner case arises when OUT_W equals IN_W.
    assign w_sext      = OUT_W'($signed(data));
    assign w_byte_sext = OUT_W'($signed(data[7:0]));

    // Select the extension for the requested mode; reserved codes flag err.
    always_comb begin
        result = '0;
        err    = 1'b0;
        case (mode)
            MODE_SIGN:      result = w_sext;
            MODE_ZERO:      result = OUT_W'(data);
            MODE_UPPER:     result = OUT_W'(data) << IN_W;
            MODE_SIGN_SHL2: result = w_sext << 2;
            MODE_BYTE_SIGN: result = w_byte_sext;
            default:        err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender behind a valid/ready handshake. A main
// register drives the outputs and a skid register absorbs one extra word so
// that in_ready can be a pure function of the registered state.
module imm_extend_pipe
    import cpu_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    input  logic [MODE_W-1:0] in_mode,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [OUT_W-1:0]   r_m_data;
    logic [TAG_W-1:0]   r_m_tag;
    logic               r_m_err;
    logic [OUT_W-1:0]   r_s_data;
    logic [TAG_W-1:0]   r_s_tag;
    logic               r_s_err;

    logic [OUT_W-1:0]   w_result;
    logic               w_err;
    logic               w_accept;
    logic               w_consume;
    logic               w_load_m_new;
    logic               w_load_m_skid;
    logic               w_load_s;

    // Extension is done at accept time so both registers hold final results.
    imm_extend_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .data   (in_data),
        .mode   (in_mode),
        .result (w_result),
        .err    (w_err)
    );

    assign in_ready  = (r_state != TWO);
    assign out_valid = (r_state != EMPTY);
    assign out_data  = r_m_data;
    assign out_tag   = r_m_tag;
    assign out_err   = r_m_err;

    assign w_accept  = in_valid && in_ready;
    assign w_consume = out_valid && out_ready;

    // Occupancy state register; reset empties the buffer at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next occupancy and which register loads what this cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_load_m_new  = 1'b0;
        w_load_m_skid = 1'b0;
        w_load_s      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_nxt  = ONE;
                    w_load_m_new = 1'b1;
                end
            end
            ONE: begin
                if (w_accept && w_consume) begin
                    w_load_m_new = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = TWO;
                    w_load_s    = 1'b1;
                end else if (w_consume) begin
                    w_state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (w_consume) begin
                    w_state_nxt   = ONE;
                    w_load_m_skid = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    // Main and skid payload registers, cleared on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m_data <= '0;
            r_m_tag  <= '0;
            r_m_err  <= 1'b0;
            r_s_data <= '0;
            r_s_tag  <= '0;
            r_s_err  <= 1'b0;
        end else begin
            if (w_load_m_new) begin
                r_m_data <= w_result;
                r_m_tag  <= in_tag;
                r_m_err  <= w_err;
            end else if (w_load_m_skid) begin
                r_m_data <= r_s_data;
                r_m_tag  <= r_s_tag;
                r_m_err  <= r_s_err;
            end
            if (w_load_s) begin
                r_s_data <= w_result;
                r_s_tag  <= in_tag;
                r_s_err  <= w_err;
            end
        end
    end

endmodule
